// File: rtl/countdown_pkg.sv
// Shared types and seven-segment patterns for the countdown timer.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes blank the digit.
module seg7_decoder
    import countdown_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Prescaled countdown timer with pause/load control and a two-digit 7-segment display.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the reload register instead of stopping at 0.
module countdown_timer_ctrl
    import countdown_pkg::*;
#(
    parameter int N        = 4,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         pause,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] count,
    output logic         done,
    output logic [6:0]   display1,
    output logic [6:0]   display2
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [N-1:0]  CNT_MAX = '1;
    localparam logic [N-1:0]  CNT_ONE = N'(1);

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_count, w_count_nxt;
    logic [N-1:0]  r_reload, w_reload_nxt;
    logic [PW-1:0] r_pre, w_pre_nxt;
    logic          r_done, w_done_nxt;
    logic          w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= CNT_MAX;
            r_reload <= CNT_MAX;
            r_pre    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_pre    <= w_pre_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_pre_nxt    = r_pre;
        w_done_nxt   = 1'b0;
        w_tick       = (r_pre == PRE_MAX);

        if (load) begin
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
            w_pre_nxt    = '0;
            w_state_nxt  = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (r_count != '0))
                        w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    // pause freezes the prescaler too, so a resume continues mid-step
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (!w_tick) begin
                        w_pre_nxt = r_pre + 1'b1;
                    end else begin
                        w_pre_nxt = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (r_count == '0) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = r_count - 1'b1;
                            w_done_nxt  = (r_count == CNT_ONE);
                        end
`else
                        w_count_nxt = r_count - 1'b1;
                        if (r_count == CNT_ONE) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_DONE;
                        end
`endif
                    end
                end
                ST_PAUSE: begin
                    if (start && !pause)
                        w_state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign done  = r_done;

    // count is at most 63, so both quotient and remainder fit a BCD digit
    logic [6:0] w_count7;
    logic [3:0] w_tens;
    logic [3:0] w_ones;

    assign w_count7 = 7'(r_count);
    assign w_tens   = 4'(w_count7 / 7'd10);
    assign w_ones   = 4'(w_count7 % 7'd10);

    seg7_decoder u_seg_ones (
        .i_digit (w_ones),
        .o_seg   (display1)
    );

    seg7_decoder u_seg_tens (
        .i_digit (w_tens),
        .o_seg   (display2)
    );

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of two instances.
module tb_countdown_timer_ctrl;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, pause, load;
    logic [5:0] lv;

    logic [3:0] cnt_a;
    logic       done_a;
    logic [6:0] d1_a, d2_a;
    logic [5:0] cnt_b;
    logic       done_b;
    logic [6:0] d1_b, d2_b;

    always #5 clk = ~clk;

    countdown_timer_ctrl #(.N(4), .PRESCALE(1)) dut_a (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .pause      (pause),
        .load       (load),
        .load_value (lv[3:0]),
        .count      (cnt_a),
        .done       (done_a),
        .display1   (d1_a),
        .display2   (d2_a)
    );

    countdown_timer_ctrl #(.N(6), .PRESCALE(3)) dut_b (
        .clk        (clk),
        .reset      (rst),
        .start      (start),
        .pause      (pause),
        .load       (load),
        .load_value (lv),
        .count      (cnt_b),
        .done       (done_b),
        .display1   (d1_b),
        .display2   (d2_b)
    );

    logic [6:0] SEG [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    typedef struct packed {
        int cnt;
        int rel;
        int pre;
        int st;
        bit done;
    } model_t;

    function automatic model_t reset_model(int n);
        model_t m;
        m.cnt  = (1 << n) - 1;
        m.rel  = (1 << n) - 1;
        m.pre  = 0;
        m.st   = S_IDLE;
        m.done = 1'b0;
        return m;
    endfunction

    function automatic model_t step(model_t m, bit ld, bit go, bit pa, int lvv, int presc);
        model_t r;
        r      = m;
        r.done = 1'b0;
        if (ld) begin
            r.cnt = lvv;
            r.rel = lvv;
            r.pre = 0;
            r.st  = S_IDLE;
            return r;
        end
        case (m.st)
            S_IDLE:  if (go && m.cnt != 0) r.st = S_RUN;
            S_RUN: begin
                if (pa) r.st = S_PAUSE;
                else if (m.pre < presc - 1) r.pre = m.pre + 1;
                else begin
                    r.pre = 0;
                    if (m.cnt == 0) r.cnt = m.rel;
                    else begin
                        r.cnt = m.cnt - 1;
                        if (r.cnt == 0) begin
                            r.done = 1'b1;
                            if (!AUTO) r.st = S_DONE;
                        end
                    end
                end
            end
            S_PAUSE: if (go && !pa) r.st = S_RUN;
            default: ;
        endcase
        return r;
    endfunction

    model_t ma, mb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= reset_model(4);
            mb <= reset_model(6);
        end else begin
            ma <= step(ma, load, start, pause, int'(lv[3:0]), 1);
            mb <= step(mb, load, start, pause, int'(lv), 3);
        end
    end

    int checks   = 0;
    int failures = 0;
    bit go_chk   = 1'b0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", nm, got, got, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (go_chk) begin
            chk("a_count", 32'(cnt_a), ma.cnt);
            chk("a_done", 32'(done_a), 32'(ma.done));
            chk("a_disp1", 32'(d1_a), 32'(SEG[ma.cnt % 10]));
            chk("a_disp2", 32'(d2_a), 32'(SEG[ma.cnt / 10]));
            chk("b_count", 32'(cnt_b), mb.cnt);
            chk("b_done", 32'(done_b), 32'(mb.done));
            chk("b_disp1", 32'(d1_b), 32'(SEG[mb.cnt % 10]));
            chk("b_disp2", 32'(d2_b), 32'(SEG[mb.cnt / 10]));
        end
    end

    task automatic cyc(int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    int auto_seq [0:6] = '{2, 1, 0, 3, 2, 1, 0};

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        load  = 1'b0;
        lv    = '0;
        cyc(2);
        rst    = 1'b0;
        go_chk = 1'b1;

        chk("rst_count", 32'(cnt_a), 15);
        chk("rst_disp2", 32'(d2_a), 32'(7'b1111001));
        chk("rst_disp1", 32'(d1_a), 32'(7'b0010010));
        chk("rst_count_b", 32'(cnt_b), 63);

        // full countdown from 15
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(14);
        chk("cd_at_1", 32'(cnt_a), 1);
        chk("cd_no_done", 32'(done_a), 0);
        cyc(1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        chk("cd_zero", 32'(cnt_a), 0);
        chk("cd_done", 32'(done_a), 1);
`endif
        cyc(1);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        chk("cd_done_1cyc", 32'(done_a), 0);
`endif
        start = 1'b1;
        cyc(3);
        start = 1'b0;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        chk("cd_start_ignored", 32'(cnt_a), 0);
`endif

        // pause / resume
        lv   = 6'd15;
        load = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        chk("p_at_12", 32'(cnt_a), 12);
        pause = 1'b1;
        cyc(5);
        chk("p_hold", 32'(cnt_a), 12);
        pause = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("p_resume_edge", 32'(cnt_a), 12);
        cyc(1);
        chk("p_resume_tick", 32'(cnt_a), 11);
        pause = 1'b1;
        cyc(1);
        start = 1'b1;
        cyc(3);
        chk("p_both", 32'(cnt_a), 11);
        pause = 1'b0;
        cyc(1);
        start = 1'b0;
        cyc(1);
        chk("p_after_both", 32'(cnt_a), 10);

        // load while running
        lv   = 6'd9;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("ld_count", 32'(cnt_a), 9);
        chk("ld_disp2", 32'(d2_a), 32'(7'b1000000));
        chk("ld_disp1", 32'(d1_a), 32'(7'b0010000));
        cyc(3);
        chk("ld_idle", 32'(cnt_a), 9);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        lv   = 6'd3;
        load = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("ar_start", 32'(cnt_a), 3);
        for (int i = 0; i < 7; i++) begin
            cyc(1);
            chk("ar_count", 32'(cnt_a), auto_seq[i]);
            chk("ar_done", 32'(done_a), (auto_seq[i] == 0) ? 1 : 0);
        end
`endif

        // asynchronous reset mid-run on the wide, prescaled instance
        lv   = 6'd63;
        load = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(10);
        chk("ar_b_running", 32'(cnt_b < 6'd63), 1);
        rst = 1'b1;
        #1;
        chk("async_b_count", 32'(cnt_b), 63);
        chk("async_b_disp2", 32'(d2_b), 32'(7'b0000010));
        chk("async_b_disp1", 32'(d1_b), 32'(7'b0110000));
        chk("async_a_count", 32'(cnt_a), 15);
        cyc(1);
        rst = 1'b0;

        // randomized traffic, checked by the per-cycle compare process
        repeat (3000) begin
            rst   = ($urandom_range(0, 499) == 0);
            load  = ($urandom_range(0, 24) == 0);
            start = ($urandom_range(0, 5) == 0);
            pause = ($urandom_range(0, 9) == 0);
            lv    = 6'($urandom);
            cyc(1);
        end

        rst   = 1'b0;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        cyc(2);
        go_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/countdown_timer_ctrl.md
COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, count width in bits; legal range 1..6 so the count fits two decimal digits.
REQ-002 SHALL have parameter PRESCALE, default 1, clock cycles per count step; legal range >=1.
REQ-003 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begins or resumes counting.
REQ-006 SHALL have port pause, input, 1, freezes counting.
REQ-007 SHALL have port load, input, 1, loads load_value into the count and the reload register.
REQ-008 SHALL have port load_value, input, N, value to load.
REQ-009 SHALL have port count, output, N, current count value (registered).
REQ-010 SHALL have port done, output, 1, one-cycle pulse when the count reaches 0.
REQ-011 SHALL have port display1, output, 7, ones digit of count, active-low {g,f,e,d,c,b,a}.
REQ-012 SHALL have port display2, output, 7, tens digit of count, same encoding.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-014 SHALL, in RUN, advance the prescaler 0..PRESCALE-1 each cycle; a tick occurs when the prescaler wraps, and count decrements by 1 on each tick.
REQ-015 SHALL, on the tick where count goes 1->0, assert done for exactly that clock cycle (registered with count=0) and enter DONE.
REQ-016 SHALL treat load as highest priority in every state: next cycle count=load_value, reload register=load_value, prescaler=0, state IDLE, done=0.
REQ-017 SHALL move IDLE->RUN on start only when count!=0; start with count==0 is ignored.
REQ-018 SHALL move RUN->PAUSE on pause and hold both count and prescaler; PAUSE->RUN on start with the prescaler resuming from its held value.
REQ-019 SHALL let pause win when pause and start are both asserted (RUN stays or goes to PAUSE; PAUSE stays PAUSE).
REQ-020 SHALL, in DONE, hold count=0 and ignore start/pause; only load or reset leave DONE.
REQ-021 SHALL form display digits combinationally from the registered count: tens=count/10, ones=count%10.
REQ-022 SHALL use this digit encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-023 SHALL, on reset assertion and without waiting for a clock edge, set count=2^N-1, reload register=2^N-1, prescaler=0, state IDLE and done=0.
REQ-024 SHALL apply the same reset values when reset occurs mid-RUN or mid-PAUSE.

Configuration
REQ-025 SHALL compile auto-reload only when macro COUNTDOWN_AUTO_RELOAD_EN is defined.
REQ-026 SHALL, with the macro defined, stay in RUN when count reaches 0 (done still pulses) and load count from the reload register on the next tick; DONE is then unreachable.
REQ-027 SHALL, without the macro, behave exactly as REQ-015 and REQ-020.

Structure
REQ-028 SHALL place the state enum typedef and the ten segment-pattern constants in shared package countdown_pkg.
REQ-029 SHALL instantiate sub-module seg7_decoder (4-bit digit in, 7-bit active-low segments out) once per display.

Verification
REQ-030 SHALL cover reset with N=4: count=15, display2=1111001, display1=0010010, state IDLE.
REQ-031 SHALL cover a full countdown with N=4, PRESCALE=1 and a 1-cycle start: count goes 15->0 in 15 cycles, done is high exactly 1 cycle with count=0, then count stays 0 and start is ignored.
REQ-032 SHALL cover pause: pause at count=12 held for 5 cycles keeps count=12; a later start resumes 12->11 on the next tick; pause+start together keeps PAUSE.
REQ-033 SHALL cover load during RUN: load_value=9 gives count=9 and IDLE next cycle; display2=1000000, display1=0010000.
REQ-034 SHALL cover auto-reload (COUNTDOWN_AUTO_RELOAD_EN defined, PRESCALE=1): load 3 then start gives count sequence 3,2,1,0,3,2,1,0 with done pulsing every 4 cycles.
REQ-035 SHALL cover asynchronous reset mid-RUN with N=6, PRESCALE=3: count=63 immediately, before the next clk edge.
